// File: rtl/wavelet_pkg.sv
// Shared FSM state encoding and default width constants for the serial FIR MAC.
package wavelet_pkg;

  localparam int DEF_TOTAL_TAPS   = 9;
  localparam int DEF_BITS_PER_TAP = 8;
  localparam int DEF_COEFF_BITS   = 8;
  localparam int DEF_OUT_BITS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

endpackage : wavelet_pkg

// File: rtl/fir_mac_serial_if.sv
// Request/result bundle of fir_mac_serial; master drives the tap vector, slave is the filter.
interface fir_mac_serial_if
  import wavelet_pkg::*;
#(
  parameter int TOTAL_TAPS   = DEF_TOTAL_TAPS,
  parameter int BITS_PER_TAP = DEF_BITS_PER_TAP,
  parameter int COEFF_BITS   = DEF_COEFF_BITS,
  parameter int OUT_BITS     = DEF_OUT_BITS
) ();

  logic                                 i_start_calc;
  logic [TOTAL_TAPS*BITS_PER_TAP-1:0]   i_taps;
  logic [TOTAL_TAPS*COEFF_BITS-1:0]     i_coeffs;
  logic signed [OUT_BITS-1:0]           o_result;
  logic                                 o_valid;
  logic                                 o_busy;
  logic                                 o_overrun;

  modport master (
    output i_start_calc, i_taps, i_coeffs,
    input  o_result, o_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_start_calc, i_taps, i_coeffs,
    output o_result, o_valid, o_busy, o_overrun
  );

endinterface : fir_mac_serial_if

// File: rtl/fir_mac_serial_mac_unit.sv
// Signed multiply-accumulate datapath: one product per enabled cycle, synchronous clear.
module mac_unit #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int PROD_W = A_W + B_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // Product and next accumulator value; clear wins over enable.
  always_comb begin
    prod_s = PROD_W'(a_i) * PROD_W'(b_i);
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule : mac_unit

// File: rtl/fir_mac_serial.sv
// Serial FIR: one multiplier walks TOTAL_TAPS products, then formats the sum.
// Define FIR_MAC_SAT_EN to saturate the output instead of wrapping it.
module fir_mac_serial
  import wavelet_pkg::*;
#(
  parameter int TOTAL_TAPS   = DEF_TOTAL_TAPS,
  parameter int BITS_PER_TAP = DEF_BITS_PER_TAP,
  parameter int COEFF_BITS   = DEF_COEFF_BITS,
  parameter int OUT_BITS     = DEF_OUT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_mac_serial_if.slave  bus
);

  localparam int PROD_W = BITS_PER_TAP + COEFF_BITS;
  localparam int ACC_W  = PROD_W + $clog2(TOTAL_TAPS);
  localparam int IDX_W  = (TOTAL_TAPS > 1) ? $clog2(TOTAL_TAPS) : 1;

  fir_state_e                          state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [TOTAL_TAPS*BITS_PER_TAP-1:0]  taps_q;
  logic [TOTAL_TAPS*COEFF_BITS-1:0]    coeffs_q;
  logic signed [OUT_BITS-1:0]          result_q, result_d;
  logic                                valid_q, valid_d;
  logic                                busy_q;
  logic                                overrun_q, overrun_d;

  logic                                snap_s;
  logic                                mac_clr_s;
  logic                                mac_en_s;
  logic signed [BITS_PER_TAP-1:0]      tap_sel_s;
  logic signed [COEFF_BITS-1:0]        coeff_sel_s;
  logic signed [ACC_W-1:0]             acc_s;
  logic signed [OUT_BITS-1:0]          fmt_s;

  assign tap_sel_s   = $signed(taps_q[idx_q*BITS_PER_TAP +: BITS_PER_TAP]);
  assign coeff_sel_s = $signed(coeffs_q[idx_q*COEFF_BITS +: COEFF_BITS]);

  mac_unit #(
    .A_W   (BITS_PER_TAP),
    .B_W   (COEFF_BITS),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr_s),
    .en_i  (mac_en_s),
    .a_i   (tap_sel_s),
    .b_i   (coeff_sel_s),
    .acc_o (acc_s)
  );

`ifdef FIR_MAC_SAT_EN
  localparam int EXT_W = (ACC_W > OUT_BITS) ? ACC_W : OUT_BITS;
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  logic signed [EXT_W-1:0] acc_ext_s;

  // Clamp the full-precision sum into the signed output range.
  always_comb begin
    acc_ext_s = EXT_W'(acc_s);
    if (acc_ext_s > SAT_MAX) begin
      fmt_s = SAT_MAX[OUT_BITS-1:0];
    end else if (acc_ext_s < SAT_MIN) begin
      fmt_s = SAT_MIN[OUT_BITS-1:0];
    end else begin
      fmt_s = acc_ext_s[OUT_BITS-1:0];
    end
  end
`else
  // Two's-complement wrap: keep the low OUT_BITS bits of the sum.
  always_comb begin
    fmt_s = OUT_BITS'(acc_s);
  end
`endif

  // Next state, datapath controls and output strobes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_s    = 1'b0;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    valid_d   = 1'b0;
    result_d  = result_q;
    overrun_d = bus.i_start_calc && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start_calc) begin
          snap_s    = 1'b1;
          mac_clr_s = 1'b1;
          idx_d     = '0;
          state_d   = ST_ACC;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ACC: begin
        mac_en_s = 1'b1;
        if (idx_q == IDX_W'(TOTAL_TAPS - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        result_d = fmt_s;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= (state_d != ST_IDLE);
      overrun_q <= overrun_d;
    end
  end

  // Operand snapshot taken on an accepted start, so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q   <= '0;
      coeffs_q <= '0;
    end else if (snap_s) begin
      taps_q   <= bus.i_taps;
      coeffs_q <= bus.i_coeffs;
    end else begin
      taps_q   <= taps_q;
      coeffs_q <= coeffs_q;
    end
  end

  assign bus.o_result  = result_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_overrun = overrun_q;

endmodule : fir_mac_serial

// File: doc/fir_mac_serial.md
FIR_MAC_SERIAL -- requirements
Module: fir_mac_serial

Interface
REQ-001 SHALL have parameter TOTAL_TAPS, default 9, number of filter taps.
REQ-002 SHALL have parameter BITS_PER_TAP, default 8, signed sample width per tap.
REQ-003 SHALL have parameter COEFF_BITS, default 8, signed coefficient width.
REQ-004 SHALL have parameter OUT_BITS, default 16, signed result width.
REQ-005 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_start_calc, input, 1, single-cycle pulse meaning the tap vector is valid.
REQ-008 SHALL have port i_taps, input, TOTAL_TAPS*BITS_PER_TAP, packed signed taps; tap k occupies bits [k*BITS_PER_TAP +: BITS_PER_TAP], tap 0 newest.
REQ-009 SHALL have port i_coeffs, input, TOTAL_TAPS*COEFF_BITS, packed signed coefficients, same packing as i_taps.
REQ-010 SHALL have port o_result, output, OUT_BITS, signed filter sum.
REQ-011 SHALL have port o_valid, output, 1, single-cycle strobe; o_result is new in that cycle.
REQ-012 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port o_overrun, output, 1, single-cycle pulse when a start is dropped.

Function
REQ-014 SHALL compute o_result = sum over k of i_taps[k]*i_coeffs[k], using one multiplier over TOTAL_TAPS cycles.
REQ-015 SHALL implement FSM states IDLE, ACC and DONE.
REQ-016 IDLE: on an edge with i_start_calc=1, SHALL snapshot i_taps and i_coeffs, clear the accumulator and index, and go to ACC.
REQ-017 ACC: each edge SHALL add the signed product tap[idx]*coeff[idx] to the accumulator and increment idx; after idx=TOTAL_TAPS-1, SHALL go to DONE.
REQ-018 DONE: SHALL register the output-formatted accumulator into o_result, pulse o_valid for exactly one cycle, and return to IDLE.
REQ-019 Latency SHALL be TOTAL_TAPS+1 edges from the start edge to the edge that raises o_valid (10 at default).
REQ-020 Product width SHALL be BITS_PER_TAP+COEFF_BITS, and accumulator width SHALL be product width + clog2(TOTAL_TAPS); accumulation SHALL never overflow internally.
REQ-021 i_start_calc while not in IDLE (including the DONE cycle) SHALL be ignored, SHALL raise o_overrun for one cycle, and SHALL leave the computation in flight unaffected.
REQ-022 i_taps and i_coeffs changes after the start edge SHALL NOT affect the result in flight.
REQ-023 o_result SHALL hold its value between o_valid strobes.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE and clear the accumulator and idx; o_result SHALL reset to 0, and o_valid, o_busy and o_overrun SHALL reset to 0.
REQ-025 Reset mid-computation SHALL abort the computation with no o_valid strobe; the first start after release SHALL compute normally.

Configuration
REQ-026 With macro FIR_MAC_SAT_EN defined, the output formatting SHALL saturate the accumulator to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-027 Without FIR_MAC_SAT_EN, the output formatting SHALL truncate to the low OUT_BITS bits (two's-complement wrap).

Structure
REQ-028 The FSM state encoding and the default width constants SHALL live in shared package wavelet_pkg.
REQ-029 The multiply-accumulate datapath SHALL be a sub-module, mac_unit, with accumulator clear and enable inputs; the FSM, index counter and output formatting SHALL stay in fir_mac_serial.

Verification
REQ-030 All taps=1, all coeffs=1, start pulse -> o_valid exactly 10 cycles later with o_result=9, and o_busy high for those 10 cycles.
REQ-031 Impulse test: tap3=5, coeff3=-7, all others 0 -> o_result=-35.
REQ-032 All taps=-128, all coeffs=-128 -> o_result=32767 with FIR_MAC_SAT_EN, and 16384 (wrapped) without it.
REQ-033 Second start 4 cycles after the first, with i_taps changed -> o_overrun pulse the next cycle, a single o_valid, and the result of the first tap set.
REQ-034 rst_n low 5 cycles after start -> o_busy and o_result go to 0 immediately and no o_valid appears; a start after release gives the correct result.
REQ-035 Back-to-back starts with a start one cycle after o_valid -> both accepted with correct results and no o_overrun.
